// File: rtl/mqnic_mcf_defs.sv
// Shared constants for MAC control frame (PAUSE/PFC) generation: frame size,
// field byte offsets, well-known ethertype/opcodes and the FSM state type.
package mqnic_mcf_defs;

  localparam int MCF_FRAME_BYTES = 60;
  localparam int MCF_FRAME_BITS  = MCF_FRAME_BYTES * 8;

  localparam int OFF_ETH_DST  = 0;
  localparam int OFF_ETH_SRC  = 6;
  localparam int OFF_ETH_TYPE = 12;
  localparam int OFF_OPCODE   = 14;
  localparam int OFF_PARAMS   = 16;
  localparam int OFF_PAD      = 34;

  localparam logic [15:0] ETH_TYPE_MCF = 16'h8808;
  localparam logic [15:0] OPCODE_LFC   = 16'h0001;
  localparam logic [15:0] OPCODE_PFC   = 16'h0101;
  localparam logic [47:0] MCAST_DST    = 48'h0180C2000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_MCF
  } mcf_state_t;

endpackage

// File: rtl/mqnic_mcf_frame_builder.sv
// Packs control frame request fields into a byte-ordered 60-byte frame,
// frame byte N at bits [8N+7:8N]; everything past the params is zero padding.
module mqnic_mcf_frame_builder
  import mqnic_mcf_defs::*;
#(
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic [47:0]                  eth_dst,
  input  logic [47:0]                  eth_src,
  input  logic [15:0]                  eth_type,
  input  logic [15:0]                  opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0] params,
  output logic [MCF_FRAME_BITS-1:0]    frame
);

  // Header fields go out in network order; params are already byte-ordered.
  always_comb begin
    frame = '0;
    for (int i = 0; i < 6; i++) begin
      frame[(OFF_ETH_DST+i)*8 +: 8] = eth_dst[(5-i)*8 +: 8];
      frame[(OFF_ETH_SRC+i)*8 +: 8] = eth_src[(5-i)*8 +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      frame[(OFF_ETH_TYPE+i)*8 +: 8] = eth_type[(1-i)*8 +: 8];
      frame[(OFF_OPCODE+i)*8 +: 8]   = opcode[(1-i)*8 +: 8];
    end
    for (int i = 0; i < MCF_PARAMS_SIZE; i++) begin
      frame[(OFF_PARAMS+i)*8 +: 8] = params[i*8 +: 8];
    end
  end

endmodule

// File: rtl/mqnic_l2_egress_mcf_tx.sv
// Egress MAC control frame generator: buffers one PAUSE/PFC request and
// inserts it as a 60-byte frame between packets of the pass-through stream.
module mqnic_l2_egress_mcf_tx
  import mqnic_mcf_defs::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_WIDTH      = 8,
  parameter int USER_WIDTH      = 1,
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  input  logic [ID_WIDTH-1:0]          s_axis_tid,
  input  logic [DEST_WIDTH-1:0]        s_axis_tdest,

  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic [ID_WIDTH-1:0]          m_axis_tid,
  output logic [DEST_WIDTH-1:0]        m_axis_tdest,

  input  logic                         mcf_valid,
  output logic                         mcf_ready,
  input  logic [47:0]                  mcf_eth_dst,
  input  logic [47:0]                  mcf_eth_src,
  input  logic [15:0]                  mcf_eth_type,
  input  logic [15:0]                  mcf_opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  input  logic [ID_WIDTH-1:0]          mcf_id,
  input  logic [DEST_WIDTH-1:0]        mcf_dest,
  input  logic [USER_WIDTH-1:0]        mcf_user,

  input  logic                         cfg_mcf_tx_enable,
  output logic                         stat_tx_mcf
);

  localparam int BEATS      = (MCF_FRAME_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST_BYTES = MCF_FRAME_BYTES - (BEATS - 1) * KEEP_WIDTH;
  localparam int PAD_BITS   = BEATS * DATA_WIDTH;
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP = {KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH - LAST_BYTES);

  mcf_state_t                state, state_next;
  logic [CNT_W-1:0]          count, count_next;
  logic                      pending;
  logic [MCF_FRAME_BITS-1:0] built_frame, pend_frame;
  logic [PAD_BITS-1:0]       frame_pad;
  logic [DATA_WIDTH-1:0]     beat_data;
  logic [ID_WIDTH-1:0]       pend_id;
  logic [DEST_WIDTH-1:0]     pend_dest;
  logic [USER_WIDTH-1:0]     pend_user;
  logic                      accept, mcf_last, mcf_done;

  mqnic_mcf_frame_builder #(
    .MCF_PARAMS_SIZE(MCF_PARAMS_SIZE)
  ) u_builder (
    .eth_dst  (mcf_eth_dst),
    .eth_src  (mcf_eth_src),
    .eth_type (mcf_eth_type),
    .opcode   (mcf_opcode),
    .params   (mcf_params),
    .frame    (built_frame)
  );

  assign mcf_ready   = rst && cfg_mcf_tx_enable && !pending;
  assign accept      = mcf_valid && mcf_ready;
  assign frame_pad   = PAD_BITS'(pend_frame);
  assign beat_data   = frame_pad[int'(count) * DATA_WIDTH +: DATA_WIDTH];
  assign mcf_last    = (count == LAST_CNT);
  assign mcf_done    = (state == ST_MCF) && m_axis_tready && mcf_last;
  assign stat_tx_mcf = mcf_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 1'b0;
      pend_frame <= '0;
      pend_id    <= '0;
      pend_dest  <= '0;
      pend_user  <= '0;
    end else if (accept) begin
      pending    <= 1'b1;
      pend_frame <= built_frame;
      pend_id    <= mcf_id;
      pend_dest  <= mcf_dest;
      pend_user  <= mcf_user;
    end else if (mcf_done) begin
      pending    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // In IDLE the stream is also held during the accept cycle itself, so a
  // request that arrives together with a new packet is sent ahead of it.
  always_comb begin
    state_next    = state;
    count_next    = count;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tlast  = s_axis_tlast;
    m_axis_tuser  = s_axis_tuser;
    m_axis_tid    = s_axis_tid;
    m_axis_tdest  = s_axis_tdest;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_next = ST_MCF;
        end else if (!accept) begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          if (s_axis_tvalid && m_axis_tready && !s_axis_tlast) state_next = ST_PASS;
        end
      end
      ST_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_next = ST_IDLE;
      end
      ST_MCF: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = beat_data;
        m_axis_tkeep  = mcf_last ? LAST_KEEP : {KEEP_WIDTH{1'b1}};
        m_axis_tlast  = mcf_last;
        m_axis_tuser  = pend_user;
        m_axis_tid    = pend_id;
        m_axis_tdest  = pend_dest;
        if (m_axis_tready) begin
          if (mcf_last) begin
            count_next = '0;
            state_next = ST_IDLE;
          end else begin
            count_next = count + CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!rst) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
    end
  end

endmodule
